// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Snoops histogram writes from process_fft and finds, per FFT frame, the
//   strongest bin inside [MIN_BIN, MAX_BIN]. The frame result is qualified
//   with an amplitude threshold and a multi-frame stability counter.
//
// Ports
//   clk          104 MHz system clock (process_fft domain)
//   reset_n      asynchronous active-low reset
//   hwe          histogram write strobe
//   haddr        histogram write address (bits [10:0] used)
//   hdata        histogram write data, unsigned bin magnitude
//   peak_valid   one-cycle pulse when the frame result updates
//   peak_bin     bin index of the frame maximum
//   peak_mag     magnitude at peak_bin
//   note_present peak_mag >= THRESH
//   note_stable  note held for STABLE_FRAMES consecutive frames
//   stable_count consecutive-match count, saturating at STABLE_FRAMES
//   frame_err    one-cycle pulse when a frame is aborted by an early address 0
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an address-0 write to start a frame
// SCAN   | tracking the running maximum over the frame's writes
// REPORT | one cycle: publish result, update stability, accept next start
module fft_peak_detect #(
  parameter int unsigned MIN_BIN       = 2,
  parameter int unsigned MAX_BIN       = 511,
  parameter int unsigned LAST_ADDR     = 1023,
  parameter logic [15:0] THRESH        = 16'h0400,
  parameter int unsigned TOL           = 1,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hwe,
  input  logic [11:0] haddr,
  input  logic [15:0] hdata,
  output logic        peak_valid,
  output logic [10:0] peak_bin,
  output logic [15:0] peak_mag,
  output logic        note_present,
  output logic        note_stable,
  output logic [3:0]  stable_count,
  output logic        frame_err
);

  localparam logic [10:0] MIN_B  = MIN_BIN[10:0];
  localparam logic [10:0] MAX_B  = MAX_BIN[10:0];
  localparam logic [10:0] LAST_A = LAST_ADDR[10:0];
  localparam logic [11:0] TOL_D  = TOL[11:0];
  localparam logic [3:0]  STAB_N = STABLE_FRAMES[3:0];

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      state, state_next;
  logic [10:0] addr;
  logic        in_band;
  logic        clear_max;
  logic        sample;
  logic        abort;
  logic        do_report;
  logic [15:0] max_mag;
  logic [10:0] max_bin;
  logic [10:0] prev_bin;
  logic [15:0] base_mag;
  logic        present_next;
  logic signed [11:0] bin_diff;
  logic [11:0] bin_dist;
  logic [3:0]  count_next;
  logic        unused_haddr_msb;

  assign unused_haddr_msb = haddr[11];
  assign addr    = haddr[10:0];
  assign in_band = (addr >= MIN_B) && (addr <= MAX_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear_max  = 1'b0;
    sample     = 1'b0;
    abort      = 1'b0;
    do_report  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hwe && addr == 11'd0) begin
          clear_max  = 1'b1;
          sample     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (hwe) begin
          sample = 1'b1;
          if (addr == 11'd0) begin
            // restart: the address-0 write itself opens the new frame
            clear_max = 1'b1;
            abort     = 1'b1;
          end else if (addr == LAST_A) begin
            state_next = REPORT;
          end
        end
      end
      REPORT: begin
        do_report  = 1'b1;
        state_next = IDLE;
        if (hwe && addr == 11'd0) begin
          clear_max  = 1'b1;
          sample     = 1'b1;
          state_next = SCAN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A frame start compares against a cleared max in the same cycle, so the
  // start write can itself become the peak when MIN_BIN is 0.
  assign base_mag = clear_max ? 16'd0 : max_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_mag <= 16'd0;
      max_bin <= 11'd0;
    end else if (sample && in_band && hdata > base_mag) begin
      max_mag <= hdata;
      max_bin <= addr;
    end else if (clear_max) begin
      max_mag <= 16'd0;
      max_bin <= MIN_B;
    end
  end

  // Stability evaluation uses the running max directly; in REPORT nothing
  // can have modified it yet, since a new start only lands at the clock edge.
  assign present_next = (max_mag >= THRESH);
  assign bin_diff     = $signed({1'b0, max_bin}) - $signed({1'b0, prev_bin});
  assign bin_dist     = bin_diff[11] ? $unsigned(-bin_diff) : $unsigned(bin_diff);

  always_comb begin
    count_next = 4'd0;
    if (present_next) begin
      if (bin_dist <= TOL_D)
        count_next = (stable_count >= STAB_N) ? STAB_N : stable_count + 4'd1;
      else
        count_next = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_valid   <= 1'b0;
      peak_bin     <= 11'd0;
      peak_mag     <= 16'd0;
      note_present <= 1'b0;
      note_stable  <= 1'b0;
      stable_count <= 4'd0;
      prev_bin     <= 11'd0;
      frame_err    <= 1'b0;
    end else begin
      peak_valid <= do_report;
      frame_err  <= abort;
      if (do_report) begin
        peak_bin     <= max_bin;
        peak_mag     <= max_mag;
        note_present <= present_next;
        stable_count <= count_next;
        note_stable  <= (count_next == STAB_N);
        prev_bin     <= max_bin;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

  logic        clk;
  logic        reset_n;
  logic        hwe;
  logic [11:0] haddr;
  logic [15:0] hdata;
  logic        peak_valid;
  logic [10:0] peak_bin;
  logic [15:0] peak_mag;
  logic        note_present;
  logic        note_stable;
  logic [3:0]  stable_count;
  logic        frame_err;

  fft_peak_detect dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hwe          (hwe),
    .haddr        (haddr),
    .hdata        (hdata),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .note_present (note_present),
    .note_stable  (note_stable),
    .stable_count (stable_count),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;

  always @(negedge clk) begin
    if (peak_valid) pv_cnt <= pv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  // A frame: every address gets the fill value (or its own address), except
  // up to four special bins. Unused special slots point at bin 2047.
  typedef struct {
    bit          fill_addr;
    logic [15:0] fill;
    int          b0; logic [15:0] m0;
    int          b1; logic [15:0] m1;
    int          b2; logic [15:0] m2;
    int          b3; logic [15:0] m3;
    int          e_bin;
    logic [15:0] e_mag;
    bit          e_pres;
    int          e_cnt;
    bit          e_stab;
  } frame_t;

  frame_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gen(input frame_t f, input int a);
    logic [15:0] d;
    d = f.fill_addr ? 16'(a) : f.fill;
    if (a == f.b0) d = f.m0;
    if (a == f.b1) d = f.m1;
    if (a == f.b2) d = f.m2;
    if (a == f.b3) d = f.m3;
    return d;
  endfunction

  task automatic write(input int a, input logic [15:0] d);
    @(negedge clk);
    hwe   = 1'b1;
    haddr = 12'(a);
    hdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hwe = 1'b0;
    end
  endtask

  task automatic send_range(input frame_t f, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) write(a, gen(f, a));
  endtask

  // Called right after the LAST_ADDR write has been driven.
  task automatic check_report(input frame_t f, input string tag);
    @(negedge clk); hwe = 1'b0;
    check({tag, " valid_n1"}, 32'(peak_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid_n2"}, 32'(peak_valid), 32'd1);
    check({tag, " bin"},      32'(peak_bin), 32'(f.e_bin));
    check({tag, " mag"},      32'(peak_mag), 32'(f.e_mag));
    check({tag, " present"},  32'(note_present), 32'(f.e_pres));
    check({tag, " count"},    32'(stable_count), 32'(f.e_cnt));
    check({tag, " stable"},   32'(note_stable), 32'(f.e_stab));
    @(negedge clk);
    check({tag, " valid_n3"}, 32'(peak_valid), 32'd0);
  endtask

  function automatic frame_t mk(bit fa, logic [15:0] fill,
                                int b0, logic [15:0] m0, int b1, logic [15:0] m1,
                                int b2, logic [15:0] m2, int b3, logic [15:0] m3,
                                int eb, logic [15:0] em, bit ep, int ec, bit es);
    frame_t f;
    f.fill_addr = fa; f.fill = fill;
    f.b0 = b0; f.m0 = m0; f.b1 = b1; f.m1 = m1;
    f.b2 = b2; f.m2 = m2; f.b3 = b3; f.m3 = m3;
    f.e_bin = eb; f.e_mag = em; f.e_pres = ep; f.e_cnt = ec; f.e_stab = es;
    return f;
  endfunction

  initial begin
    frame_t f;
    int pv0;
    int fe0;

    tbl[0]  = mk(1, 16'h0000, 100, 16'h2000, 2047, 0, 2047, 0, 2047, 0, 100, 16'h2000, 1, 1, 0);
    tbl[1]  = mk(0, 16'h0010, 101, 16'h2000, 2047, 0, 2047, 0, 2047, 0, 101, 16'h2000, 1, 2, 0);
    tbl[2]  = mk(0, 16'h0010, 100, 16'h2000, 2047, 0, 2047, 0, 2047, 0, 100, 16'h2000, 1, 3, 1);
    tbl[3]  = mk(0, 16'h0010, 200, 16'h2000, 2047, 0, 2047, 0, 2047, 0, 200, 16'h2000, 1, 1, 0);
    tbl[4]  = mk(0, 16'h0100, 2047, 0, 2047, 0, 2047, 0, 2047, 0,          2, 16'h0100, 0, 0, 0);
    tbl[5]  = mk(0, 16'h0000, 1, 16'h5000, 40, 16'h5000, 60, 16'h5000, 600, 16'hFFFF,
                 40, 16'h5000, 1, 1, 0);
    tbl[6]  = mk(0, 16'h0000, 2047, 0, 2047, 0, 2047, 0, 2047, 0,          2, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(0, 16'h0010, 511, 16'h0400, 2047, 0, 2047, 0, 2047, 0,  511, 16'h0400, 1, 1, 0);
    tbl[8]  = mk(0, 16'h0010, 512, 16'hFFFF, 510, 16'h0400, 2047, 0, 2047, 0,
                 510, 16'h0400, 1, 2, 0);
    tbl[9]  = mk(0, 16'h0010, 511, 16'h0400, 2047, 0, 2047, 0, 2047, 0,  511, 16'h0400, 1, 3, 1);
    tbl[10] = mk(0, 16'h0010, 511, 16'h0400, 2047, 0, 2047, 0, 2047, 0,  511, 16'h0400, 1, 3, 1);
    tbl[11] = mk(0, 16'h0010, 511, 16'h03FF, 2047, 0, 2047, 0, 2047, 0,  511, 16'h03FF, 0, 0, 0);

    reset_n = 1'b0;
    hwe     = 1'b0;
    haddr   = 12'd0;
    hdata   = 16'd0;
    idle(3);
    check("rst valid",   32'(peak_valid),   32'd0);
    check("rst bin",     32'(peak_bin),     32'd0);
    check("rst mag",     32'(peak_mag),     32'd0);
    check("rst present", 32'(note_present), 32'd0);
    check("rst stable",  32'(note_stable),  32'd0);
    check("rst count",   32'(stable_count), 32'd0);
    check("rst err",     32'(frame_err),    32'd0);
    reset_n = 1'b1;
    idle(2);

    // Writes before any address 0 must be ignored.
    f = mk(0, 16'hFFFF, 2047, 0, 2047, 0, 2047, 0, 2047, 0, 0, 0, 0, 0, 0);
    pv0 = pv_cnt;
    send_range(f, 1000, 1023);
    idle(4);
    check("no start valid", 32'(pv_cnt - pv0), 32'd0);

    for (int i = 0; i < 12; i++) begin
      pv0 = pv_cnt;
      send_range(tbl[i], 0, 1023);
      check_report(tbl[i], $sformatf("frame%0d", i));
      idle(1);
      check($sformatf("frame%0d pulses", i), 32'(pv_cnt - pv0), 32'd1);
    end

    // Abort: address 0 reissued after 500; the strong bin 250 must be forgotten.
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    f = mk(0, 16'h0010, 250, 16'h7000, 2047, 0, 2047, 0, 2047, 0, 0, 0, 0, 0, 0);
    send_range(f, 0, 500);
    f = mk(0, 16'h0010, 300, 16'h3000, 2047, 0, 2047, 0, 2047, 0, 300, 16'h3000, 1, 1, 0);
    write(0, 16'h0010);
    @(negedge clk); hwe = 1'b0;
    check("abort err pulse", 32'(frame_err), 32'd1);
    @(negedge clk);
    check("abort err width", 32'(frame_err), 32'd0);
    send_range(f, 1, 1023);
    check_report(f, "abort");
    idle(2);
    check("abort err count",   32'(fe_cnt - fe0), 32'd1);
    check("abort valid count", 32'(pv_cnt - pv0), 32'd1);

    // Reset in the middle of a frame.
    send_range(f, 0, 700);
    @(negedge clk);
    hwe = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst valid",   32'(peak_valid),   32'd0);
    check("midrst bin",     32'(peak_bin),     32'd0);
    check("midrst mag",     32'(peak_mag),     32'd0);
    check("midrst present", 32'(note_present), 32'd0);
    check("midrst count",   32'(stable_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pv0 = pv_cnt;
    send_range(f, 701, 1023);
    idle(4);
    check("midrst tail valid", 32'(pv_cnt - pv0), 32'd0);
    send_range(f, 0, 1023);
    check_report(f, "postrst");

    // Back-to-back frames: next address 0 arrives in the REPORT cycle.
    pv0 = pv_cnt;
    f = mk(0, 16'h0010, 301, 16'h3000, 2047, 0, 2047, 0, 2047, 0, 301, 16'h3000, 1, 2, 0);
    send_range(f, 0, 1023);
    f = mk(0, 16'h0010, 300, 16'h3000, 2047, 0, 2047, 0, 2047, 0, 300, 16'h3000, 1, 3, 1);
    send_range(f, 0, 1023);
    check_report(f, "b2b");
    idle(1);
    check("b2b pulses", 32'(pv_cnt - pv0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
